mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin arbiter that generates the 2-bit select for the 4:1 data multiplexer in the datapath. It takes four request lines and grants exactly one requester at a time. It drives the grant's `sel` code plus a one-hot grant vector, and holds the selection stable until the owner releases it. The mux consumes `sel` directly; `valid` qualifies the mux output for downstream logic.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles when the hold timeout is compiled in. Legal range is 2..255.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request lines; `req[i]` asks for mux channel i.
- `done`, input, 1: owner releases the current grant; sampled only in GRANT.
- `sel`, output, 2: mux select code of the current/last grant.
- `grant`, output, 4: one-hot grant; all zero when idle.
- `valid`, output, 1: high while a grant is active, i.e. `sel` is qualified.
- `timeout`, output, 1: one-cycle pulse on a forced release; constant 0 when the feature is compiled out.

## Operation
- Registered state:
  - FSM {IDLE, GRANT}.
  - 2-bit last-grant pointer `ptr`.
  - Output registers.
  - Optional hold counter.
- Reset values (asynchronous on `rst_n`=0):
  - state=IDLE, `sel`=2'b00, `grant`=4'b0000, `valid`=0, `timeout`=0.
  - `ptr`=2'b11, so channel 0 has top priority after reset.
  - Hold counter = 0.
- IDLE, `req`==0: remain in IDLE; outputs unchanged (`sel` keeps its last value).
- IDLE, `req`!=0:
  - Winner w is the first set bit scanning ptr+1, ptr+2, ptr+3, ptr+4, all mod 4.
  - Next edge: state=GRANT, `sel`=w, `grant`=1<<w, `valid`=1, `ptr`=w, counter=0.
- GRANT, release condition: `done`=1 OR `req[sel]`=0 at the edge.
  - Next edge: state=IDLE, `valid`=0, `grant`=0.
  - `sel` and `ptr` hold.
- GRANT, no release: all outputs hold; counter increments (feature enabled).
- `done` in IDLE is ignored. Changes on other `req` bits during GRANT are ignored; no preemption.
- Simultaneous `done`=1 and `req[sel]`=0: a single release, identical to either alone.
- `sel` never changes while `valid`=1. `grant` is always zero or one-hot and equals 1<<`sel` whenever `valid`=1.

## Timing
- Grant latency: requests sampled at edge N produce `valid`/`grant`/`sel` updated after edge N. That is one cycle from request to grant.
- Release latency: a release condition sampled at edge M takes effect after edge M. `valid` is low for at least one full cycle between consecutive grants.
- Back-to-back throughput with continuous requests and 1-cycle holds: one grant per 2 cycles.
- Fairness: with all four requests held, grants rotate 0,1,2,3,0,…. No channel waits more than 3 intervening grants.
- Reset mid-grant: outputs clear immediately (asynchronous) and `ptr` returns to 2'b11. The first grant after `rst_n` rises follows the normal IDLE rule.

## Configuration
- `MUX_SEL_HOLD_TIMEOUT_EN` defined:
  - The hold counter is present, width $clog2(MAX_HOLD+1).
  - When the counter reaches MAX_HOLD-1 in GRANT with no release, the next edge forces the release. `timeout`=1 for that one cycle, coincident with `valid` falling.
  - A grant is therefore at most MAX_HOLD cycles long.
  - A normal release on the same edge takes priority: no `timeout` pulse.
- Not defined:
  - No counter; `timeout` is tied to 0.
  - A grant lasts until `done` or the requester drops `req`, with no upper bound.

## Test plan
- Reset, including mid-grant:
  - Assert `rst_n`=0 -> `sel`=00, `grant`=0000, `valid`=0, `timeout`=0 immediately.
  - During GRANT on channel 2, asserting `rst_n`=0 clears outputs without waiting for a clock edge.
- Single request:
  - `req`=0001 after reset -> next edge `grant`=0001, `sel`=00, `valid`=1.
  - Pulse `done` -> `valid`=0, `grant`=0000 next edge, `sel` stays 00.
- Rotation:
  - `req`=1111 held, `done` pulsed once per grant -> `sel` sequence 00,01,10,11,00.
  - Each grant is separated by exactly one idle cycle.
- Pointer priority: after a grant to channel 1, `req`=0011 -> `grant`=0001 (scan order 2,3,0,1).
- Requester drop: grant on channel 2 (`req`=0100), then `req` goes to 0000 with `done`=0 -> `valid` falls next edge, `timeout`=0.
- Timeout, MAX_HOLD=4:
  - With the macro: `req`=0100 held, `done`=0 -> `valid` high exactly 4 cycles, `timeout` pulses with its fall, regrant to channel 2 after one idle cycle.
  - Without the macro: `valid` stays high for 20+ cycles and `timeout` remains 0.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: four-way round-robin arbiter that drives the 2-bit select
// of the datapath 4:1 mux, a one-hot grant and a qualifying valid.
// A grant is held until the owner pulses done or drops its request.
// Optional macro MUX_SEL_HOLD_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD cycles and pulses timeout on that release.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q, valid_d;

  logic [1:0] win;
  logic       any_req;
  logic       release_c;
  logic       hold_expired;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("mux_sel_arbiter: MAX_HOLD must be in 2..255");
  end

  assign any_req   = |req;
  assign release_c = done | ~req[sel_q];

  // Round-robin winner: first set request scanning ptr+1 .. ptr+4 (mod 4).
  // Iterating from the farthest slot down lets the nearest slot win last.
  always_comb begin
    logic [1:0] idx;
    win = ptr_q;
    idx = ptr_q;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = ptr_q + k[1:0];
      if (req[idx]) win = idx;
    end
  end

`ifdef MUX_SEL_HOLD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  assign hold_expired = (state_q == GRANT) && (cnt_q == CW'(MAX_HOLD - 1));

  // Hold counter: cleared on a new grant, counts held cycles; a normal
  // release on the expiry edge suppresses the timeout pulse.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (any_req) cnt_d = '0;
    end else if (!release_c) begin
      if (hold_expired) timeout_d = 1'b1;
      else              cnt_d     = cnt_q + CW'(1);
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Next-state and output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = win;
          ptr_d   = win;
          grant_d = 4'b0001 << win;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (release_c || hold_expired) begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      sel_q   <= 2'b00;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: behavioural owner/hold model,
// per-cycle comparison, directed literal checks and randomized traffic.
module tb_mux_sel_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mux_sel_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the mux, for how many cycles, who went last.
  bit m_valid;
  int m_sel;
  int m_last;
  int m_held;
  bit m_timeout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_sel = 0; m_last = 3; m_held = 0; m_timeout = 0;
    end else begin
      m_timeout = 0;
      if (!m_valid) begin
        for (int k = 4; k >= 1; k--) begin
          if (req[(m_last + k) % 4]) m_sel = (m_last + k) % 4;
        end
        if (req != 4'b0000) begin
          m_last = m_sel; m_valid = 1; m_held = 1;
        end
      end else if (done || !req[m_sel]) begin
        m_valid = 0;
      end else begin
`ifdef MUX_SEL_HOLD_TIMEOUT_EN
        if (m_held == HOLD) begin
          m_valid = 0; m_timeout = 1;
        end else
`endif
        m_held++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("sel",     32'(sel),     32'(m_sel));
    chk("grant",   32'(grant),   m_valid ? (32'd1 << m_sel) : 32'd0);
    chk("valid",   32'(valid),   32'(m_valid));
    chk("timeout", 32'(timeout), 32'(m_timeout));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int run_len;

  initial begin
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    tick(); tick();
    rst_n = 1'b1;

    // Single request then done.
    req = 4'b0001; tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_sel", 32'(sel), 0);
    chk("single_valid", 32'(valid), 1);
    done = 1'b1; tick();
    chk("done_valid", 32'(valid), 0);
    chk("done_grant", 32'(grant), 0);
    chk("done_sel", 32'(sel), 0);
    done = 1'b0; req = 4'b0000; tick();

    // Grant channel 2 then reset between edges.
    req = 4'b0100; tick();
    chk("g2_sel", 32'(sel), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_sel", 32'(sel), 0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;

    // Rotation from the reset pointer with all requests held.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot_sel", 32'(sel), 32'(i % 4));
      chk("rot_valid", 32'(valid), 1);
      done = 1'b1; tick();
      chk("rot_idle", 32'(valid), 0);
      done = 1'b0;
    end
    req = 4'b0000; tick();

    // Pointer priority: after channel 1, 0011 must go to channel 0.
    req = 4'b0010; tick();
    chk("ptr_g1", 32'(sel), 1);
    done = 1'b1; tick();
    done = 1'b0; req = 4'b0011; tick();
    chk("ptr_grant", 32'(grant), 32'h1);
    done = 1'b1; tick();
    done = 1'b0; req = 4'b0000; tick();

    // Requester drop releases without a timeout.
    req = 4'b0100; tick();
    chk("drop_sel", 32'(sel), 2);
    req = 4'b0000; tick();
    chk("drop_valid", 32'(valid), 0);
    chk("drop_timeout", 32'(timeout), 0);

    // Long hold on channel 2.
    req = 4'b0100; tick();
    run_len = 0;
    while (valid && run_len < 24) begin
      run_len++; tick();
    end
`ifdef MUX_SEL_HOLD_TIMEOUT_EN
    chk("hold_len", 32'(run_len), HOLD);
    chk("hold_timeout", 32'(timeout), 1);
    tick();
    chk("regrant_valid", 32'(valid), 1);
    chk("regrant_sel", 32'(sel), 2);
    chk("regrant_timeout", 32'(timeout), 0);
`else
    chk("hold_len", 32'(run_len), 24);
    chk("hold_timeout", 32'(timeout), 0);
`endif
    req = 4'b0000; done = 1'b1; tick();
    done = 1'b0; tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1; req = 4'b0000; done = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
